// File: rtl/ooo_pkg.sv
// Shared definitions for the out-of-order issue slice.
// Instruction layout: ready bit k lives at RDY_LSB+k, and the tag of operand k
// is OP_TAG_W bits starting at OP_TAG_LSB + k*OP_TAG_W, for k = 0..NUM_OPS-1.
// Helper functions work on the default instruction width INST_W.
package ooo_pkg;

  localparam int INST_W     = 47;
  localparam int RDY_LSB    = 9;
  localparam int NUM_OPS    = 4;
  localparam int OP_TAG_W   = 6;
  localparam int OP_TAG_LSB = 13;

  // Tag of operand k.
  function automatic logic [OP_TAG_W-1:0] op_tag(input logic [INST_W-1:0] instr,
                                                 input int k);
    return instr[OP_TAG_LSB + k*OP_TAG_W +: OP_TAG_W];
  endfunction

  // Set the ready bit of every operand whose tag equals the broadcast tag.
  function automatic logic [INST_W-1:0] apply_wakeup(input logic [INST_W-1:0] instr,
                                                     input logic [OP_TAG_W-1:0] tag);
    logic [INST_W-1:0] r;
    r = instr;
    for (int k = 0; k < NUM_OPS; k++)
      if (op_tag(instr, k) == tag) r[RDY_LSB + k] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/wakeup_match.sv
// Combinational wakeup of one instruction against the result broadcast.
// Ports:
//   instr_in   instruction as currently held
//   bc_valid   broadcast valid (callers fold in their own occupancy qualifier)
//   bc_tag     broadcast tag
//   instr_out  instr_in with the ready bit of every matching operand set
module wakeup_match
  import ooo_pkg::*;
#(
  parameter int INST_WIDTH = 47,
  parameter int TAG_WIDTH  = 6,
  parameter int TAG_LSB    = 13
) (
  input  logic [INST_WIDTH-1:0] instr_in,
  input  logic                  bc_valid,
  input  logic [TAG_WIDTH-1:0]  bc_tag,
  output logic [INST_WIDTH-1:0] instr_out
);

  // Ready bits are only ever OR'ed in, so they stay sticky.
  always_comb begin
    instr_out = instr_in;
    for (int k = 0; k < NUM_OPS; k++)
      if (bc_valid && (instr_in[TAG_LSB + k*TAG_WIDTH +: TAG_WIDTH] == bc_tag))
        instr_out[RDY_LSB + k] = 1'b1;
  end

endmodule

// File: rtl/wakeup_queue.sv
// In-order buffer between dispatch and issue_cap. Holds instructions until
// issued, snooping the result bus to set operand ready bits while they wait.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   flush                synchronous clear of all entries (beats push/pop/wakeup)
//   in_valid/in_instr    dispatch side; in_ready = not full
//   bc_valid/bc_tag      result broadcast
//   out_valid/out_instr  head entry (registered) to issue_cap
//   out_ready            head consumed when out_valid & out_ready
//   count                occupancy
module wakeup_queue
  import ooo_pkg::*;
#(
  parameter int INST_WIDTH = 47,
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 6,
  parameter int TAG_LSB    = 13
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [INST_WIDTH-1:0]      in_instr,
  output logic                       in_ready,
  input  logic                       bc_valid,
  input  logic [TAG_WIDTH-1:0]       bc_tag,
  output logic                       out_valid,
  output logic [INST_WIDTH-1:0]      out_instr,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [INST_WIDTH-1:0] mem_q   [DEPTH];
  logic [INST_WIDTH-1:0] mem_d   [DEPTH];
  logic [INST_WIDTH-1:0] woken   [DEPTH];
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [INST_WIDTH-1:0] push_instr;
  logic                  push, pop;

  // One matcher per resident entry; empty slots are not woken.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    wakeup_match #(
      .INST_WIDTH (INST_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH),
      .TAG_LSB    (TAG_LSB)
    ) u_match (
      .instr_in  (mem_q[i]),
      .bc_valid  (bc_valid & vld_q[i]),
      .bc_tag    (bc_tag),
      .instr_out (woken[i])
    );
  end

  // Bypass on the dispatch path so a broadcast in the push cycle is not lost.
  wakeup_match #(
    .INST_WIDTH (INST_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH),
    .TAG_LSB    (TAG_LSB)
  ) u_push_match (
    .instr_in  (in_instr),
    .bc_valid  (bc_valid),
    .bc_tag    (bc_tag),
    .instr_out (push_instr)
  );

  assign out_valid = (count_q != '0);
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_instr = mem_q[rd_ptr_q];
  assign count     = count_q;

  // in_ready ignores out_ready: a full queue refuses a push even in a pop cycle.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i]) mem_d[i] = woken[i];
    // Push and pop never target the same slot: equal pointers mean empty
    // (no pop) or full (no push).
    if (push) begin
      mem_d[wr_ptr_q] = push_instr;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = PW'(wr_ptr_q + 1'b1);
    end
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = PW'(rd_ptr_q + 1'b1);
    end
    case ({push, pop})
      2'b10:   count_d = CW'(count_q + 1'b1);
      2'b01:   count_d = CW'(count_q - 1'b1);
      default: count_d = count_q;
    endcase
    // Stale storage is left in place; only occupancy is cleared.
    if (flush) begin
      vld_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_wakeup_queue.sv
// Bench for wakeup_queue: directed table, corner-case sequences and random
// traffic, all checked against a queue-based reference model.
module tb_wakeup_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, in_valid, in_ready, bc_valid, out_valid, out_ready;
  logic [46:0] in_instr, out_instr;
  logic [5:0]  bc_tag;
  logic [2:0]  count;

  wakeup_queue dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .bc_valid  (bc_valid),
    .bc_tag    (bc_tag),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: contents in order, head at index 0.
  logic [46:0] mq[$];

  typedef struct {
    bit          fl;
    bit          iv;
    logic [46:0] ii;
    bit          bv;
    logic [5:0]  bt;
    bit          ordy;
    int          exp_cnt;   // -1 = not checked
    int          exp_rdy;   // head ready nibble, -1 = not checked
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [46:0] mk(input int t0, t1, t2, t3,
                                     input logic [3:0] rdy, input int id);
    logic [46:0] r;
    r        = '0;
    r[8:0]   = id[8:0];
    r[12:9]  = rdy;
    r[18:13] = t0[5:0];
    r[24:19] = t1[5:0];
    r[30:25] = t2[5:0];
    r[36:31] = t3[5:0];
    r[46:37] = 10'(id * 7 + 1);
    return r;
  endfunction

  // Operand k's tag sits at 13+6k; matching operands get ready bit 9+k.
  function automatic logic [46:0] wake(input logic [46:0] ins, input bit bv,
                                       input logic [5:0] bt);
    logic [46:0] r;
    r = ins;
    if (bv)
      for (int k = 0; k < 4; k++)
        if (ins[13 + 6*k +: 6] == bt) r[9 + k] = 1'b1;
    return r;
  endfunction

  function automatic vec_t mkv(input bit fl, iv, input logic [46:0] ii, input bit bv,
                               input logic [5:0] bt, input bit ordy,
                               input int ec, input int er);
    vec_t v;
    v.fl = fl; v.iv = iv; v.ii = ii; v.bv = bv; v.bt = bt; v.ordy = ordy;
    v.exp_cnt = ec; v.exp_rdy = er;
    return v;
  endfunction

  task automatic check_model();
    chk("count", 64'(count), 64'(mq.size()));
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(mq.size() != 4));
    if (mq.size() != 0) chk("head", 64'(out_instr), 64'(mq[0]));
  endtask

  // One clock: drive on the falling edge, update model at the rising edge,
  // compare 1ns later.
  task automatic step(input bit fl, iv, input logic [46:0] ii, input bit bv,
                      input logic [5:0] bt, input bit ordy);
    bit push, pop;
    int sz;
    @(negedge clk);
    flush = fl; in_valid = iv; in_instr = ii; bc_valid = bv; bc_tag = bt; out_ready = ordy;
    sz   = mq.size();
    push = iv && (sz < 4) && !fl;
    pop  = ordy && (sz != 0) && !fl;
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      foreach (mq[i]) mq[i] = wake(mq[i], bv, bt);
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(wake(ii, bv, bt));
    end
    #1;
    check_model();
  endtask

  task automatic idle();
    step(0, 0, '0, 0, '0, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 0; in_valid = 0; in_instr = '0; bc_valid = 0; bc_tag = '0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_count", 64'(count), 0);
    chk("rst_out_instr", 64'(out_instr), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: idle pop, wakeup, bypass, fill to full, refused push, drain.
    tbl.push_back(mkv(0, 0, '0, 0, 0, 1, 0, -1));
    tbl.push_back(mkv(0, 1, mk(3, 5, 7, 9, 4'b0000, 1), 0, 0, 0, 1, 4'b0000));
    tbl.push_back(mkv(0, 0, '0, 1, 5, 0, 1, 4'b0010));
    tbl.push_back(mkv(0, 0, '0, 1, 9, 0, 1, 4'b1010));
    tbl.push_back(mkv(0, 0, '0, 1, 33, 0, 1, 4'b1010));
    tbl.push_back(mkv(0, 1, mk(2, 2, 4, 6, 4'b0000, 2), 1, 2, 0, 2, 4'b1010));
    tbl.push_back(mkv(0, 0, '0, 0, 0, 1, 1, 4'b0011));
    tbl.push_back(mkv(0, 0, '0, 0, 0, 1, 0, -1));
    tbl.push_back(mkv(0, 1, mk(10, 11, 12, 13, 4'b0000, 3), 0, 0, 0, 1, 4'b0000));
    tbl.push_back(mkv(0, 1, mk(14, 15, 16, 17, 4'b0000, 4), 0, 0, 0, 2, 4'b0000));
    tbl.push_back(mkv(0, 1, mk(18, 19, 20, 21, 4'b0000, 5), 0, 0, 0, 3, 4'b0000));
    tbl.push_back(mkv(0, 1, mk(22, 23, 24, 25, 4'b0000, 6), 0, 0, 0, 4, 4'b0000));
    tbl.push_back(mkv(0, 1, mk(26, 27, 28, 29, 4'b1111, 7), 0, 0, 0, 4, 4'b0000));
    tbl.push_back(mkv(0, 1, mk(26, 27, 28, 29, 4'b1111, 7), 0, 0, 1, 3, 4'b0000));
    tbl.push_back(mkv(0, 0, '0, 0, 0, 1, 2, -1));
    tbl.push_back(mkv(0, 0, '0, 0, 0, 1, 1, -1));
    tbl.push_back(mkv(0, 0, '0, 0, 0, 1, 0, -1));
    foreach (tbl[i]) begin
      step(tbl[i].fl, tbl[i].iv, tbl[i].ii, tbl[i].bv, tbl[i].bt, tbl[i].ordy);
      if (tbl[i].exp_cnt >= 0) chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].exp_cnt));
      if (tbl[i].exp_rdy >= 0) chk($sformatf("tbl%0d_rdy", i), 64'(out_instr[12:9]), 64'(tbl[i].exp_rdy));
    end

    // Simultaneous push/pop at count 2, across pointer wrap.
    step(0, 1, mk(1, 2, 3, 4, 4'b0000, 20), 0, 0, 0);
    step(0, 1, mk(5, 6, 7, 8, 4'b0000, 21), 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, mk(i, i + 1, i + 2, i + 3, 4'b0001, 22 + i), 0, 0, 1);
      chk("pp_count", 64'(count), 2);
      chk("pp_head_id", 64'(out_instr[8:0]), 64'(21 + i));
    end
    repeat (2) step(0, 0, '0, 0, 0, 1);

    // Flush at count 3 while pushing and broadcasting.
    for (int i = 0; i < 3; i++) step(0, 1, mk(40, 41, 42, 43, 4'b0000, 30 + i), 0, 0, 0);
    step(1, 1, mk(40, 41, 42, 43, 4'b0000, 33), 1, 40, 1);
    chk("flush_count", 64'(count), 0);
    chk("flush_out_valid", 64'(out_valid), 0);
    chk("flush_in_ready", 64'(in_ready), 1);
    idle();

    // Asynchronous reset mid-cycle at count 3.
    for (int i = 0; i < 3; i++) step(0, 1, mk(50, 51, 52, 53, 4'b0101, 40 + i), 0, 0, 0);
    @(negedge clk);
    in_valid = 0; bc_valid = 0; out_ready = 0; flush = 0;
    #1 rst = 1'b1;
    #1;
    chk("arst_count", 64'(count), 0);
    chk("arst_out_valid", 64'(out_valid), 0);
    chk("arst_in_ready", 64'(in_ready), 1);
    chk("arst_out_instr", 64'(out_instr), 0);
    mq.delete();
    #1 rst = 1'b0;
    idle();

    // Random traffic against the model; small tag range to force matches.
    for (int n = 0; n < 600; n++) begin
      logic [63:0] r;
      logic [46:0] ins;
      r   = {$urandom, $urandom};
      ins = r[46:0];
      for (int k = 0; k < 4; k++) ins[13 + 6*k +: 6] = 6'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) ins[12:9] = 4'b0000;
      step($urandom_range(0, 31) == 0, $urandom_range(0, 9) < 7, ins,
           $urandom_range(0, 1) == 1, 6'($urandom_range(0, 8)),
           $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wakeup_queue.md
Name: wakeup_queue

Overview:
- In-order buffer between dispatch and issue_cap that holds dispatched instructions until their operands are ready.
- Snoops the result broadcast bus and sets the per-operand ready bits [12:9] of every waiting instruction whose source tag matches.
- Presents the head entry to issue_cap, which fires once all four ready bits are set and downstream is ready.

Parameters:
- INST_WIDTH, 47, instruction word width; ready bits fixed at [12:9].
- DEPTH, 4, number of entries; power of two, at least 2.
- TAG_WIDTH, 6, width of a result/physical tag.
- TAG_LSB, 13, LSB of operand tag 0. Operand k tag is instr[TAG_LSB+k*TAG_WIDTH +: TAG_WIDTH], k=0..3, and its ready bit is instr[9+k].

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous clear of all entries
- in_valid  in  1  dispatch offers an instruction
- in_instr  in  INST_WIDTH  dispatched instruction
- in_ready  out  1  queue can accept (= not full)
- bc_valid  in  1  result broadcast valid
- bc_tag  in  TAG_WIDTH  tag of the broadcast result
- out_valid  out  1  head entry present (to issue_cap entry_valid)
- out_instr  out  INST_WIDTH  head instruction with current ready bits (to issue_cap instr)
- out_ready  in  1  issue_cap entry_ready; head is consumed when out_valid & out_ready
- count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Storage:
  - Circular buffer with read/write pointers of $clog2(DEPTH) bits plus a count register.
  - Pointers wrap modulo DEPTH.
- Reset (async, rst=1):
  - Pointers and count go to 0; all valid flags clear.
  - out_valid=0, in_ready=1, count=0, out_instr=0.
- Push:
  - Occurs when in_valid & in_ready.
  - The entry is written at the write pointer. Ready bits are written as the incoming bit OR'ed with a same-cycle tag match against bc_tag when bc_valid=1 (bypass, so a broadcast is never missed at dispatch).
- Wakeup:
  - Each cycle with bc_valid=1, every occupied entry sets ready bit k where tag k equals bc_tag.
  - Ready bits are sticky; they never clear while the entry is resident.
  - Effect is visible on out_instr the next cycle.
- Pop:
  - Occurs when out_valid & out_ready. The read pointer advances.
  - The queue does not inspect ready bits; issue_cap gates readiness.
- out_instr is driven from storage at the read pointer, a registered value with no combinational path from bc_*.
- out_valid = (count != 0).
- in_ready = (count != DEPTH). It does not depend on out_ready, so a push into a full queue is refused even in a pop cycle.
- Simultaneous push and pop: count unchanged and both pointers advance. When count==1, the new entry becomes head on the next cycle.
- Empty: out_valid=0; out_ready is ignored.
- Full: in_ready=0; in_valid is ignored and no state changes from it.
- flush=1 takes priority over push, pop and wakeup that cycle:
  - Pointers and count go to 0.
  - The next cycle shows out_valid=0, in_ready=1.
- Reset mid-operation: all contents are discarded immediately; no partial state survives.
- Duplicate tags in one instruction: all matching operands wake together.

Decomposition:
- Shared package ooo_pkg:
  - Ready-bit LSB (9).
  - Operand count (4).
  - TAG_WIDTH, TAG_LSB.
  - Function extracting operand tag k.
  - Function applying a wakeup (instr, tag) -> instr with bits set.
- Sub-module wakeup_match:
  - Combinational: given an instruction plus bc_valid/bc_tag, returns the instruction with matched ready bits set.
  - Instantiated once per entry and once on the push path.

Test Plan:
- Reset then idle:
  - rst pulse gives out_valid=0, in_ready=1, count=0.
  - An out_ready=1 pulse on the empty queue changes nothing.
- Fill to full:
  - Push 4 instructions with distinct tags; count=4, in_ready=0.
  - A 5th in_valid is refused and contents are unchanged.
  - Pop order matches push order.
- Wakeup:
  - Head has tags {3,5,7,9} with ready=0000. Broadcast 5 then 9.
  - out_instr[12:9] becomes 0010, then 1010, each one cycle after its broadcast.
  - Tags not present cause no change.
- Dispatch-cycle bypass:
  - Push tags {2,2,4,6}, ready=0000, with bc_valid=1, bc_tag=2 in the same cycle.
  - The stored entry reads ready=0011 on the next cycle.
- Push/pop same cycle:
  - count=2 with in_valid & out_ready both high for 3 cycles; count stays 2.
  - Order is preserved across pointer wrap (pointers pass index 3 back to 0).
- Flush and async reset:
  - With count=3, assert flush while pushing and broadcasting; next cycle count=0, out_valid=0.
  - Repeat with rst asserted mid-cycle; outputs clear without waiting for a clock edge.
